// File: rtl/mask_frame_sequencer.sv
// Frame sequencer: raster-reads the camera BRAM into the extraction pipeline and
// collects mask results into a ping-pong BRAM. States: IDLE | ISSUE reads | DRAIN last masks | DONE swap bank.
module mask_frame_sequencer #(
  parameter int H_PIX    = 320,
  parameter int V_PIX    = 240,
  parameter int ADDR_W   = 17,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pipe_ready,
  output logic              busy,
  output logic              done,
  output logic              cam_rd_en,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [15:0]       cam_data,
  output logic [15:0]       pix_out,
  output logic              pix_valid,
  output logic [10:0]       pix_x,
  output logic [9:0]        pix_y,
  input  logic              mask_bit,
  input  logic              mask_valid,
  output logic              mask_we,
  output logic [ADDR_W-1:0] mask_addr,
  output logic              mask_din,
  output logic              mask_bank,
  output logic [ADDR_W-1:0] green_count
);

  localparam int                N      = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
  localparam logic [10:0]       X_LAST = 11'(H_PIX - 1);
  localparam logic [9:0]        Y_LAST = 10'(V_PIX - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] green_q, green_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              bank_q, bank_d;
  logic              issue, wr_ok, done_c, flush;

  logic [READ_LAT-1:0] vld_dl_q;
  logic [10:0]         x_dl_q [READ_LAT];
  logic [9:0]          y_dl_q [READ_LAT];

  logic              mask_we_q, mask_din_q;
  logic [ADDR_W-1:0] mask_addr_q;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    acc_d    = acc_q;
    green_d  = green_q;
    x_d      = x_q;
    y_d      = y_q;
    bank_d   = bank_q;
    done_c   = 1'b0;

    flush = abort && (state_q != S_IDLE);
    issue = (state_q == S_ISSUE) && pipe_ready && !abort;
    wr_ok = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && mask_valid &&
            (wr_cnt_q < N_A) && !abort;

    if (wr_ok) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      acc_d    = acc_q + ADDR_W'(mask_bit);
    end

    if (issue) begin
      rd_cnt_d = rd_cnt_q + ADDR_W'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_ISSUE;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          acc_d    = '0;
          x_d      = '0;
          y_d      = '0;
        end
      end
      S_ISSUE: if (issue && (rd_cnt_q == LAST_A)) state_d = S_DRAIN;
      S_DRAIN: if (wr_cnt_q == N_A) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        done_c  = 1'b1;
        bank_d  = ~bank_q;
        green_d = acc_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including the bank swap of a DONE cycle.
    if (flush) begin
      state_d = S_IDLE;
      done_c  = 1'b0;
      bank_d  = bank_q;
      green_d = green_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      acc_q       <= '0;
      green_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bank_q      <= 1'b0;
      vld_dl_q    <= '0;
      mask_we_q   <= 1'b0;
      mask_din_q  <= 1'b0;
      mask_addr_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        x_dl_q[i] <= '0;
        y_dl_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      acc_q    <= acc_d;
      green_q  <= green_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bank_q   <= bank_d;

      if (flush) begin
        vld_dl_q <= '0;
      end else begin
        vld_dl_q[0] <= issue;
        for (int i = 1; i < READ_LAT; i++) vld_dl_q[i] <= vld_dl_q[i-1];
      end
      x_dl_q[0] <= x_q;
      y_dl_q[0] <= y_q;
      for (int i = 1; i < READ_LAT; i++) begin
        x_dl_q[i] <= x_dl_q[i-1];
        y_dl_q[i] <= y_dl_q[i-1];
      end

      mask_we_q <= wr_ok;
      if (wr_ok) begin
        mask_addr_q <= wr_cnt_q;
        mask_din_q  <= mask_bit;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_c;
  assign cam_rd_en   = issue;
  assign cam_addr    = rd_cnt_q;
  assign pix_valid   = vld_dl_q[READ_LAT-1];
  assign pix_out     = pix_valid ? cam_data : 16'h0000;
  assign pix_x       = x_dl_q[READ_LAT-1];
  assign pix_y       = y_dl_q[READ_LAT-1];
  assign mask_we     = mask_we_q;
  assign mask_addr   = mask_addr_q;
  assign mask_din    = mask_din_q;
  assign mask_bank   = bank_q;
  assign green_count = green_q;

endmodule

// File: tb/tb_mask_frame_sequencer.sv
// Directed bench for mask_frame_sequencer on a reduced 32x24 frame so that
// several whole frames fit in a short run; BRAM, L=3 pipeline and mask BRAM are modelled here.
module tb_mask_frame_sequencer;
  localparam int H = 32, V = 24, N = H * V, AW = 10, RL = 2;
  localparam int LAT_FULL   = N + RL + 3 + 2;
  // pipe_ready 1,1,1,0,0,0,...: last read issued at j=(N/3-1)*6+2
  localparam int LAT_TOGGLE = (N / 3 - 1) * 6 + 2 + 1 + (LAT_FULL - N);
  localparam int BUDGET     = 4000;

  logic          clk = 1'b0;
  logic          reset, start, abort, pipe_ready;
  logic          busy, done, cam_rd_en, pix_valid;
  logic [AW-1:0] cam_addr, mask_addr, green_count;
  logic [15:0]   cam_data, pix_out;
  logic [10:0]   pix_x;
  logic [9:0]    pix_y;
  logic          mask_bit, mask_valid, mask_we, mask_din, mask_bank;

  mask_frame_sequencer #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pipe_ready(pipe_ready),
    .busy(busy), .done(done), .cam_rd_en(cam_rd_en), .cam_addr(cam_addr),
    .cam_data(cam_data), .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .mask_bit(mask_bit), .mask_valid(mask_valid),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_din(mask_din),
    .mask_bank(mask_bank), .green_count(green_count));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] cam_mem [N];
  logic [15:0] rd1 = '0, rd2 = '0;
  bit          v1, v2, v3, b1, b2, b3, force_mv;

  always @(posedge clk) begin
    if (cam_rd_en && int'(cam_addr) < N) rd1 <= cam_mem[cam_addr];
    rd2 <= rd1;
    v1 <= pix_valid;
    b1 <= (pix_out[7:4] > 4'd7);
    v2 <= v1; b2 <= b1;
    v3 <= v2; b3 <= b2;
  end
  assign cam_data   = rd2;
  assign mask_valid = v3 | force_mv;
  assign mask_bit   = b3 | force_mv;

  int          rd_exp = 0, pix_k = 0, frame_id = 0;
  int          addr_bad = 0, pix_bad = 0, done_cnt = 0, we_cnt = 0;
  logic [10:0] last_x = '0;
  logic [9:0]  last_y = '0;
  bit          mask_mem [2][N];
  int          wtag     [2][N];

  always @(negedge clk) begin
    if (start && !busy && !reset) begin
      rd_exp   <= 0;
      pix_k    <= 0;
      frame_id <= frame_id + 1;
    end
    if (cam_rd_en) begin
      if (int'(cam_addr) != rd_exp) addr_bad <= addr_bad + 1;
      rd_exp <= rd_exp + 1;
    end
    if (pix_valid) begin
      if (pix_k >= N || pix_out !== cam_mem[pix_k] || int'(pix_x) != pix_k % H ||
          int'(pix_y) != pix_k / H)
        pix_bad <= pix_bad + 1;
      last_x <= pix_x;
      last_y <= pix_y;
      pix_k  <= pix_k + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (mask_we) begin
      we_cnt <= we_cnt + 1;
      if (int'(mask_addr) < N) begin
        mask_mem[mask_bank][mask_addr] <= mask_din;
        wtag[mask_bank][mask_addr]     <= frame_id;
      end
    end
  end

  function automatic bit exp_bit(int k);
    return cam_mem[k][7:4] > 4'd7;
  endfunction

  function automatic int exp_green();
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(exp_bit(k));
    return s;
  endfunction

  // exact=1: every third pixel green, with G straddling the 7/8 threshold
  task automatic fill(input bit exact);
    logic [3:0] g;
    for (int k = 0; k < N; k++) begin
      if (!exact) begin
        cam_mem[k] = 16'((k * 37) & 32'hfff);
      end else begin
        g = (k % 3 == 0) ? ((k % 2 == 0) ? 4'h8 : 4'hf) : ((k % 2 == 0) ? 4'h7 : 4'h0);
        cam_mem[k] = {4'h0, 4'(k), g, 4'(k >> 4)};
      end
    end
  endtask

  // mode 0: ready held; 1: ready toggles every 3 cycles; 2: stray start/mask_valid pulses
  task automatic run_frame(input int mode, output int lat, output logic [AW-1:0] gc_mid);
    lat    = -1;
    gc_mid = '1;
    @(posedge clk); #1 start = 1'b1; pipe_ready = 1'b1;
    for (int j = 0; j < BUDGET; j++) begin
      @(posedge clk); #1;
      start      = (mode == 2) && (j == 99 || j == N + 6);
      force_mv   = (mode == 2) && (j == N + 5 || j == N + 6);
      pipe_ready = (mode == 1) ? ((j / 3) % 2 == 0) : 1'b1;
      @(negedge clk);
      if (j == N / 2) gc_mid = green_count;
      if (done) begin
        lat = j + 1;
        break;
      end
    end
    @(posedge clk); #1 start = 1'b0; force_mv = 1'b0; pipe_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b1; pipe_ready = 1'b1; force_mv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cam_rd_en, pix_valid, mask_we, mask_din, mask_bank} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy, done, cam_rd_en, pix_valid, mask_we, mask_din, mask_bank});
    end
    checks++;
    if (cam_addr !== '0) begin errors++; $display("FAIL reset_cam_addr: got %0d expected 0", cam_addr); end
    checks++;
    if ({pix_out, pix_x, pix_y} !== '0) begin
      errors++; $display("FAIL reset_pix: got %h/%0d/%0d expected 0", pix_out, pix_x, pix_y);
    end
    checks++;
    if (mask_addr !== '0) begin errors++; $display("FAIL reset_mask_addr: got %0d expected 0", mask_addr); end
    checks++;
    if (green_count !== '0) begin errors++; $display("FAIL reset_green: got %0d expected 0", green_count); end
    @(posedge clk); #1 start = 1'b0; abort = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_frame;
    logic          b0;
    int            ab, pb, dc, wc, lat, bad;
    logic [AW-1:0] gcm;
    fill(1'b0);
    b0 = mask_bank; ab = addr_bad; pb = pix_bad; dc = done_cnt; wc = we_cnt;
    run_frame(0, lat, gcm);
    @(negedge clk);
    checks++;
    if (lat !== LAT_FULL) begin errors++; $display("FAIL full_latency: got %0d expected %0d", lat, LAT_FULL); end
    checks++;
    if (done_cnt - dc !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt - dc); end
    checks++;
    if (mask_bank !== ~b0) begin errors++; $display("FAIL full_bank: got %b expected %b", mask_bank, ~b0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b expected 0", busy); end
    checks++;
    if (addr_bad !== ab || rd_exp !== N) begin
      errors++; $display("FAIL full_addr_seq: bad=%0d reads=%0d expected bad=0 reads=%0d", addr_bad - ab, rd_exp, N);
    end
    checks++;
    if (pix_bad !== pb || pix_k !== N) begin
      errors++; $display("FAIL full_pixels: bad=%0d seen=%0d expected bad=0 seen=%0d", pix_bad - pb, pix_k, N);
    end
    checks++;
    if (int'(last_x) !== H - 1 || int'(last_y) !== V - 1) begin
      errors++; $display("FAIL full_last_xy: got (%0d,%0d) expected (%0d,%0d)", last_x, last_y, H - 1, V - 1);
    end
    checks++;
    if (we_cnt - wc !== N) begin errors++; $display("FAIL full_writes: got %0d expected %0d", we_cnt - wc, N); end
    checks++;
    if (int'(green_count) !== exp_green()) begin
      errors++; $display("FAIL full_green: got %0d expected %0d", green_count, exp_green());
    end
    bad = 0;
    for (int k = 0; k < N; k++) if (mask_mem[b0][k] !== exp_bit(k) || wtag[b0][k] !== frame_id) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_image: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_exact_green;
    logic          b0;
    logic [AW-1:0] gc_prev, gcm;
    int            lat, bad;
    fill(1'b1);
    b0 = mask_bank; gc_prev = green_count;
    run_frame(0, lat, gcm);
    @(negedge clk);
    checks++;
    if (gcm !== gc_prev) begin errors++; $display("FAIL green_hold_midframe: got %0d expected %0d", gcm, gc_prev); end
    checks++;
    if (green_count !== AW'(256)) begin errors++; $display("FAIL exact_green: got %0d expected 256", green_count); end
    checks++;
    if (mask_bank !== ~b0) begin errors++; $display("FAIL exact_bank: got %b expected %b", mask_bank, ~b0); end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (mask_mem[b0][k] !== (k % 3 == 0) || wtag[b0][k] !== frame_id) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL exact_image: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_throttle;
    logic          b0;
    logic [AW-1:0] gcm;
    int            ab, pb, dc, lat, bad;
    fill(1'b0);
    b0 = mask_bank; ab = addr_bad; pb = pix_bad; dc = done_cnt;
    run_frame(1, lat, gcm);
    @(negedge clk);
    checks++;
    if (lat !== LAT_TOGGLE) begin errors++; $display("FAIL throttle_latency: got %0d expected %0d", lat, LAT_TOGGLE); end
    checks++;
    if (addr_bad !== ab || rd_exp !== N || pix_bad !== pb) begin
      errors++; $display("FAIL throttle_stream: addr_bad=%0d reads=%0d pix_bad=%0d expected 0/%0d/0",
                         addr_bad - ab, rd_exp, pix_bad - pb, N);
    end
    checks++;
    if (done_cnt - dc !== 1 || mask_bank !== ~b0) begin
      errors++; $display("FAIL throttle_done: dones=%0d bank=%b expected 1/%b", done_cnt - dc, mask_bank, ~b0);
    end
    bad = 0;
    for (int k = 0; k < N; k++) if (mask_mem[b0][k] !== exp_bit(k) || wtag[b0][k] !== frame_id) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL throttle_image: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_abort;
    logic          b0;
    logic [AW-1:0] gc0, gcm;
    int            dc, lat, bad;
    fill(1'b1);
    b0 = mask_bank; gc0 = green_count; dc = done_cnt;
    @(posedge clk); #1 start = 1'b1;
    for (int j = 0; j <= 500; j++) begin
      @(posedge clk); #1 start = 1'b0; abort = (j == 500);
    end
    @(negedge clk);
    checks++;
    if (cam_addr !== AW'(500) || pix_valid !== 1'b1) begin
      errors++; $display("FAIL abort_point: addr=%0d pix_valid=%b expected 500/1", cam_addr, pix_valid);
    end
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL abort_flush: got %b expected 0", pix_valid); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== dc || mask_bank !== b0 || green_count !== gc0) begin
      errors++; $display("FAIL abort_state: dones=%0d bank=%b green=%0d expected 0/%b/%0d",
                         done_cnt - dc, mask_bank, green_count, b0, gc0);
    end
    run_frame(0, lat, gcm);
    @(negedge clk);
    checks++;
    if (lat !== LAT_FULL || mask_bank !== ~b0 || green_count !== AW'(256)) begin
      errors++; $display("FAIL abort_restart: lat=%0d bank=%b green=%0d expected %0d/%b/256",
                         lat, mask_bank, green_count, LAT_FULL, ~b0);
    end
    bad = 0;
    for (int k = 0; k < N; k++)
      if (mask_mem[b0][k] !== (k % 3 == 0) || wtag[b0][k] !== frame_id) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL abort_restart_image: got %0d wrong words expected 0", bad); end
  endtask

  task automatic test_busy_guards;
    logic [AW-1:0] gcm;
    int            ab, dc, wc, lat;
    fill(1'b0);
    ab = addr_bad; dc = done_cnt; wc = we_cnt;
    run_frame(2, lat, gcm);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL guard_start_in_done: busy=%b expected 0", busy); end
    @(posedge clk); #1 force_mv = 1'b1;
    @(posedge clk); #1 force_mv = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (lat !== LAT_FULL || addr_bad !== ab) begin
      errors++; $display("FAIL guard_start_busy: lat=%0d addr_bad=%0d expected %0d/0", lat, addr_bad - ab, LAT_FULL);
    end
    checks++;
    if (we_cnt - wc !== N) begin errors++; $display("FAIL guard_extra_writes: got %0d expected %0d", we_cnt - wc, N); end
    checks++;
    if (done_cnt - dc !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL guard_done: dones=%0d busy=%b expected 1/0", done_cnt - dc, busy);
    end
  endtask

  task automatic test_reset_midframe;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (200) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, pix_valid, cam_rd_en, mask_bank} !== 4'b0 || green_count !== '0) begin
      errors++; $display("FAIL reset_midframe: busy/pv/rd/bank=%b green=%0d expected 0000/0",
                         {busy, pix_valid, cam_rd_en, mask_bank}, green_count);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_exact_green();
    test_throttle();
    test_abort();
    test_busy_guards();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
